// File: rtl/self_sync_descrambler.sv
// Self-synchronising serial descrambler for x^58 + x^39 + 1 with a fill/lock tracker.
// Build option: define DESCRAMBLER_FILL_GATE_EN to suppress data_valid_out until locked.
module self_sync_descrambler #(
  parameter int unsigned FILL_LEN = 58
) (
  input  logic clk,
  input  logic rst,
  input  logic scrambled_data_in,
  input  logic data_valid_in,
  input  logic resync,
  output logic serial_data_out,
  output logic data_valid_out,
  output logic locked
);

  localparam int unsigned SR_W  = 58;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TAP_A = 38;
  localparam int unsigned TAP_B = 57;

  typedef enum logic {
    FILLING = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [SR_W-1:0]   r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dout;
  logic              r_dvo;
  logic              r_locked;
  logic              w_accept;
  logic              w_fill_done;
  logic              w_dvo_next;
  logic              w_descr;

  // resync takes priority over a coincident valid bit, which is dropped
  assign w_accept    = data_valid_in & ~resync;
  assign w_fill_done = (r_cnt >= CNT_W'(FILL_LEN - 1));
  assign w_descr     = scrambled_data_in ^ r_shift[TAP_A] ^ r_shift[TAP_B];

  // Lock FSM next state and registered-output precursors
  always_comb begin
    w_state_next = r_state;
    w_dvo_next   = 1'b0;
    case (r_state)
      FILLING: begin
        if (w_accept && w_fill_done) begin
          w_state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (resync) begin
          w_state_next = FILLING;
        end
      end
      default: w_state_next = FILLING;
    endcase
`ifdef DESCRAMBLER_FILL_GATE_EN
    w_dvo_next = w_accept && (r_state == LOCKED);
`else
    w_dvo_next = w_accept;
`endif
  end

  // State, shift register, fill counter and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FILLING;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_dout   <= 1'b0;
      r_dvo    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_dvo    <= w_dvo_next;
      r_locked <= (w_state_next == LOCKED);
      if (resync) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (data_valid_in) begin
        // the line bit, not the descrambled bit, feeds the register
        r_shift <= {r_shift[SR_W-2:0], scrambled_data_in};
        r_dout  <= w_descr;
        if (r_cnt < CNT_W'(FILL_LEN)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign serial_data_out = r_dout;
  assign data_valid_out  = r_dvo;
  assign locked          = r_locked;

endmodule

// File: tb/tb_self_sync_descrambler.sv
// Directed bench for self_sync_descrambler: zero stream, loopback, error spread, gaps, resync, reset.
module tb_self_sync_descrambler;

  localparam int FILL = 58;
`ifdef DESCRAMBLER_FILL_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic scrambled_data_in;
  logic data_valid_in;
  logic resync;
  logic serial_data_out;
  logic data_valid_out;
  logic locked;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [14:0] prbs;
  logic [57:0] hist;
  int          fill;
  bit          aligned;
  logic        last_exp;

  self_sync_descrambler #(.FILL_LEN(FILL)) dut (
    .clk              (clk),
    .rst              (rst),
    .scrambled_data_in(scrambled_data_in),
    .data_valid_in    (data_valid_in),
    .resync           (resync),
    .serial_data_out  (serial_data_out),
    .data_valid_out   (data_valid_out),
    .locked           (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic rs, input logic rr);
    @(negedge clk);
    data_valid_in     = v;
    scrambled_data_in = d;
    resync            = rs;
    rst               = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    prbs     = 15'h0001;
    hist     = '0;
    fill     = 0;
    aligned  = 1'b1;
    last_exp = 1'b0;
  endtask

  // PRBS15 source followed by a zero-seeded x^58+x^39+1 scrambler
  task automatic next_bits(output logic src, output logic scr);
    src  = prbs[14] ^ prbs[13];
    prbs = {prbs[13:0], src};
    scr  = src ^ hist[38] ^ hist[57];
    hist = {hist[56:0], scr};
  endtask

  task automatic stream_bit(input string tag, input logic flip, input logic wrong);
    logic src;
    logic scr;
    logic exp_v;
    int   fb;
    next_bits(src, scr);
    fb = fill;
    drive(1'b1, scr ^ flip, 1'b0, 1'b0);
    fill++;
    exp_v = !GATE || (fb >= FILL);
    chk({tag, "_dvo"}, data_valid_out, exp_v);
    chk({tag, "_lock"}, locked, (fill >= FILL) ? 1'b1 : 1'b0);
    if (exp_v && (aligned || fb >= FILL)) begin
      chk({tag, "_data"}, serial_data_out, src ^ wrong);
    end
    last_exp = src ^ wrong;
  endtask

  task automatic idle_bit(input string tag);
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk({tag, "_idle_dvo"}, data_valid_out, 1'b0);
    chk({tag, "_idle_hold"}, serial_data_out, last_exp);
    chk({tag, "_idle_lock"}, locked, (fill >= FILL) ? 1'b1 : 1'b0);
  endtask

  initial begin
    logic src;
    logic scr;
    int   fb;
    int   acc;
    int   guard;

    rst = 1'b1; data_valid_in = 1'b0; scrambled_data_in = 1'b0; resync = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_dout", serial_data_out, 1'b0);
    chk("rst_dvo", data_valid_out, 1'b0);
    chk("rst_lock", locked, 1'b0);

    // all-zero line stream
    model_reset();
    for (int i = 1; i <= 200; i++) begin
      fb = fill;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      fill++;
      chk("zero_data", serial_data_out, 1'b0);
      chk("zero_dvo", data_valid_out, (!GATE || fb >= FILL) ? 1'b1 : 1'b0);
      chk("zero_lock", locked, (fill >= FILL) ? 1'b1 : 1'b0);
    end

    // continuous loopback
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    for (int i = 1; i <= 2000; i++) stream_bit("loop", 1'b0, 1'b0);

    // single line error spreads to bits k, k+39, k+58
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    for (int i = 1; i <= 700; i++) begin
      stream_bit("err", (i == 500) ? 1'b1 : 1'b0,
                 (i == 500 || i == 539 || i == 558) ? 1'b1 : 1'b0);
    end

    // sparse valid, ~30% duty
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    acc   = 0;
    guard = 0;
    while (acc < 1000 && guard < 20000) begin
      guard++;
      if ($urandom_range(0, 9) < 3) begin
        stream_bit("gap", 1'b0, 1'b0);
        acc++;
      end else begin
        idle_bit("gap");
      end
    end
    chk("gap_budget", (acc == 1000) ? 1'b1 : 1'b0, 1'b1);

    // resync at bit 300 with coincident valid, then reset at bit 700
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    for (int i = 1; i <= 299; i++) stream_bit("pre", 1'b0, 1'b0);
    next_bits(src, scr);
    drive(1'b1, scr, 1'b1, 1'b0);
    chk("rsy_dvo", data_valid_out, 1'b0);
    chk("rsy_lock", locked, 1'b0);
    chk("rsy_hold", serial_data_out, last_exp);
    fill    = 0;
    aligned = 1'b0;
    for (int i = 301; i <= 699; i++) stream_bit("rsy", 1'b0, 1'b0);
    next_bits(src, scr);
    drive(1'b1, scr, 1'b1, 1'b1);
    chk("mrst_dout", serial_data_out, 1'b0);
    chk("mrst_dvo", data_valid_out, 1'b0);
    chk("mrst_lock", locked, 1'b0);
    fill     = 0;
    aligned  = 1'b0;
    last_exp = 1'b0;
    for (int i = 701; i <= 800; i++) stream_bit("rrst", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
